// File: rtl/vga_sync_pkg.sv
// Shared 640x480@60 timing constants for vga_sync and the graphics stages
// (MAX_X/MAX_Y), plus the modulo-counter next-value helper.
package vga_sync_pkg;

  localparam int CNT_W = 10;

  localparam int VGA_HD = 640;
  localparam int VGA_HF = 16;
  localparam int VGA_HR = 96;
  localparam int VGA_HB = 48;
  localparam int VGA_VD = 480;
  localparam int VGA_VF = 10;
  localparam int VGA_VR = 2;
  localparam int VGA_VB = 33;

  localparam int VGA_H_TOTAL = VGA_HD + VGA_HF + VGA_HR + VGA_HB;
  localparam int VGA_V_TOTAL = VGA_VD + VGA_VF + VGA_VR + VGA_VB;
  localparam int VGA_TICK_DIV = 2;

  localparam int MAX_X = VGA_HD;
  localparam int MAX_Y = VGA_VD;

  typedef struct packed {
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } pix_pos_t;

  // Value a mod-n counter will hold after the next edge.
  function automatic logic [CNT_W-1:0] count_next(input logic [CNT_W-1:0] q,
                                                   input logic en,
                                                   input int n);
    if (!en) return q;
    if (q == CNT_W'(n - 1)) return '0;
    return q + CNT_W'(1);
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Enabled modulo-N up-counter; wrap flags the terminal count N-1.
module mod_n_counter #(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         wrap
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  assign wrap = (q_q == W'(N - 1));
  assign q    = q_q;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = wrap ? '0 : q_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/vga_sync.sv
// VGA scan timing generator: pixel-tick divider, h/v scan counters, registered syncs.
// Optional frame_tick output is built only when VGA_SYNC_FRAME_TICK_EN is defined.
module vga_sync
  import vga_sync_pkg::*;
#(
  parameter int TICK_DIV = VGA_TICK_DIV,
  parameter int HD       = VGA_HD,
  parameter int HF       = VGA_HF,
  parameter int HR       = VGA_HR,
  parameter int HB       = VGA_HB,
  parameter int VD       = VGA_VD,
  parameter int VF       = VGA_VF,
  parameter int VR       = VGA_VR,
  parameter int VB       = VGA_VB
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             p_tick,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y
`ifdef VGA_SYNC_FRAME_TICK_EN
  ,
  output logic             frame_tick
`endif
);

  localparam int H_TOTAL = HD + HF + HR + HB;
  localparam int V_TOTAL = VD + VF + VR + VB;
  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CNT_W-1:0] HS_START = CNT_W'(HD + HF);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(HD + HF + HR - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(VD + VF);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(VD + VF + VR - 1);

  logic [TICK_W-1:0] tick_cnt_q;
  logic [TICK_W-1:0] tick_cnt_d;
  logic              hsync_q;
  logic              hsync_d;
  logic              vsync_q;
  logic              vsync_d;
  logic              h_wrap;
  logic              v_wrap;
  logic              v_en;
  pix_pos_t          pos_next;

  assign p_tick = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
  assign v_en   = p_tick & h_wrap;

  mod_n_counter #(
    .N(H_TOTAL),
    .W(CNT_W)
  ) h_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (p_tick),
    .q      (pix_x),
    .wrap   (h_wrap)
  );

  mod_n_counter #(
    .N(V_TOTAL),
    .W(CNT_W)
  ) v_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (v_en),
    .q      (pix_y),
    .wrap   (v_wrap)
  );

  // Syncs are decoded from the counters' next values so they land on the
  // same edge as the count they belong to.
  always_comb begin
    tick_cnt_d = p_tick ? '0 : tick_cnt_q + TICK_W'(1);
    pos_next.x = count_next(pix_x, p_tick, H_TOTAL);
    pos_next.y = count_next(pix_y, v_en, V_TOTAL);
    hsync_d    = !((pos_next.x >= HS_START) && (pos_next.x <= HS_END));
    vsync_d    = !((pos_next.y >= VS_START) && (pos_next.y <= VS_END));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_cnt_q <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
    end
  end

  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign video_on = (pix_x < CNT_W'(HD)) && (pix_y < CNT_W'(VD));

`ifdef VGA_SYNC_FRAME_TICK_EN
  // Fires on the edge that leaves the last visible line.
  assign frame_tick = p_tick && h_wrap && (pix_y == CNT_W'(VD - 1));
`endif

  logic unused_ok;
  assign unused_ok = v_wrap;

endmodule

// File: tb/tb_vga_sync.sv
// Randomized check of vga_sync against an arithmetic reference model:
// a default 640x480 instance and a small-timing instance for whole frames.
module tb_vga_sync;

  localparam int A_D = 2, A_HD = 640, A_HF = 16, A_HR = 96, A_HB = 48;
  localparam int A_VD = 480, A_VF = 10, A_VR = 2, A_VB = 33;
  localparam int A_HT = A_HD + A_HF + A_HR + A_HB;

  localparam int B_D = 3, B_HD = 20, B_HF = 3, B_HR = 5, B_HB = 4;
  localparam int B_VD = 10, B_VF = 2, B_VR = 2, B_VB = 3;
  localparam int B_HT = B_HD + B_HF + B_HR + B_HB;
  localparam int B_VT = B_VD + B_VF + B_VR + B_VB;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       pt;
    logic       ft;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a_n, rst_b_n;
  logic       a_hs, a_vs, a_vo, a_pt, b_hs, b_vs, b_vo, b_pt;
  logic [9:0] a_x, a_y, b_x, b_y;
`ifdef VGA_SYNC_FRAME_TICK_EN
  logic       a_ft, b_ft;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int c_a      = 0;
  int c_b      = 0;
  int hcnt_a   = 0;
  int vcnt_b   = 0;

  vga_sync #(.TICK_DIV(A_D), .HD(A_HD), .HF(A_HF), .HR(A_HR), .HB(A_HB),
             .VD(A_VD), .VF(A_VF), .VR(A_VR), .VB(A_VB)) dut_a (
    .clk(clk), .reset_n(rst_a_n), .hsync(a_hs), .vsync(a_vs), .video_on(a_vo),
    .p_tick(a_pt), .pix_x(a_x), .pix_y(a_y)
`ifdef VGA_SYNC_FRAME_TICK_EN
    , .frame_tick(a_ft)
`endif
  );

  vga_sync #(.TICK_DIV(B_D), .HD(B_HD), .HF(B_HF), .HR(B_HR), .HB(B_HB),
             .VD(B_VD), .VF(B_VF), .VR(B_VR), .VB(B_VB)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .hsync(b_hs), .vsync(b_vs), .video_on(b_vo),
    .p_tick(b_pt), .pix_x(b_x), .pix_y(b_y)
`ifdef VGA_SYNC_FRAME_TICK_EN
    , .frame_tick(b_ft)
`endif
  );

  // c = clock edges since the last reset edge; every output follows from
  // the pixel index c / d.
  function automatic exp_t ref_model(input int c, input int d, input int hd, input int hf,
                                     input int hr, input int hb, input int vd, input int vf,
                                     input int vr, input int vb);
    exp_t e;
    int ht, vt, p, x, y;
    ht = hd + hf + hr + hb;
    vt = vd + vf + vr + vb;
    p  = c / d;
    x  = p % ht;
    y  = (p / ht) % vt;
    e.x  = 10'(x);
    e.y  = 10'(y);
    e.pt = ((c % d) == d - 1);
    e.hs = !((x >= hd + hf) && (x < hd + hf + hr));
    e.vs = !((y >= vd + vf) && (y < vd + vf + vr));
    e.vo = (x < hd) && (y < vd);
    e.ft = e.pt && (x == ht - 1) && (y == vd - 1);
    return e;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    exp_t ea, eb;
    ea = ref_model(c_a, A_D, A_HD, A_HF, A_HR, A_HB, A_VD, A_VF, A_VR, A_VB);
    eb = ref_model(c_b, B_D, B_HD, B_HF, B_HR, B_HB, B_VD, B_VF, B_VR, B_VB);
    check_val("a.pix_x", 32'(a_x), 32'(ea.x));
    check_val("a.pix_y", 32'(a_y), 32'(ea.y));
    check_val("a.hsync", 32'(a_hs), 32'(ea.hs));
    check_val("a.vsync", 32'(a_vs), 32'(ea.vs));
    check_val("a.video_on", 32'(a_vo), 32'(ea.vo));
    check_val("a.p_tick", 32'(a_pt), 32'(ea.pt));
    check_val("b.pix_x", 32'(b_x), 32'(eb.x));
    check_val("b.pix_y", 32'(b_y), 32'(eb.y));
    check_val("b.hsync", 32'(b_hs), 32'(eb.hs));
    check_val("b.vsync", 32'(b_vs), 32'(eb.vs));
    check_val("b.video_on", 32'(b_vo), 32'(eb.vo));
    check_val("b.p_tick", 32'(b_pt), 32'(eb.pt));
`ifdef VGA_SYNC_FRAME_TICK_EN
    check_val("a.frame_tick", 32'(a_ft), 32'(ea.ft));
    check_val("b.frame_tick", 32'(b_ft), 32'(eb.ft));
`endif
    if (a_pt === 1'b1 && a_hs === 1'b0) hcnt_a++;
    if (ea.pt && ea.x == 10'(A_HT - 1)) begin
      check_val("a.hsync_low_ticks", 32'(hcnt_a), 32'(A_HR));
      hcnt_a = 0;
    end
    if (b_pt === 1'b1 && b_vo === 1'b1) vcnt_b++;
    if (eb.pt && eb.x == 10'(B_HT - 1) && eb.y == 10'(B_VT - 1)) begin
      check_val("b.video_on_ticks", 32'(vcnt_b), 32'(B_HD * B_VD));
      vcnt_b = 0;
    end
  endtask

  task automatic step(input logic ra, input logic rb);
    rst_a_n = ra;
    rst_b_n = rb;
    @(posedge clk);
    if (!ra) begin
      c_a    = 0;
      hcnt_a = 0;
    end else begin
      c_a++;
    end
    if (!rb) begin
      c_b    = 0;
      vcnt_b = 0;
    end else begin
      c_b++;
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int k;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    check_val("a.reset_x", 32'(a_x), 32'd0);
    check_val("a.reset_hsync", 32'(a_hs), 32'd1);
    check_val("a.reset_vsync", 32'(a_vs), 32'd1);
    check_val("a.reset_video_on", 32'(a_vo), 32'd1);
    $display("phase reset done: checks=%0d errors=%0d", n_checks, n_fail);

    for (int i = 0; i < 4000; i++) step(1'b1, 1'b1);
    $display("phase free-run done: checks=%0d errors=%0d", n_checks, n_fail);

    for (int i = 0; i < 30000; i++) begin
      logic ra, rb;
      ra = ($urandom_range(2999, 0) != 0);
      rb = ($urandom_range(2999, 0) != 0);
      step(ra, rb);
    end
    $display("phase random-reset done: checks=%0d errors=%0d", n_checks, n_fail);

    for (k = 0; k < 4000 && !(b_x == 10'd25 && b_y == 10'd13); k++) step(1'b1, 1'b1);
    check_val("b.reach_25_13", 32'(k < 4000), 32'd1);
    step(1'b1, 1'b0);
    check_val("b.midframe_rst_x", 32'(b_x), 32'd0);
    check_val("b.midframe_rst_y", 32'(b_y), 32'd0);
    check_val("b.midframe_rst_vsync", 32'(b_vs), 32'd1);
    for (int i = 0; i < 2000; i++) step(1'b1, 1'b1);
    $display("phase mid-frame reset b done: checks=%0d errors=%0d", n_checks, n_fail);

    for (k = 0; k < 2000 && a_x != 10'd700; k++) step(1'b1, 1'b1);
    check_val("a.reach_700", 32'(k < 2000), 32'd1);
    step(1'b0, 1'b1);
    check_val("a.midline_rst_x", 32'(a_x), 32'd0);
    check_val("a.midline_rst_hsync", 32'(a_hs), 32'd1);
    check_val("a.midline_rst_vsync", 32'(a_vs), 32'd1);
    for (int i = 0; i < 3500; i++) step(1'b1, 1'b1);
    $display("phase mid-line reset a done: checks=%0d errors=%0d", n_checks, n_fail);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
